lsu_unit: RTL

//  Per-thread load/store unit: parametrised successor to the load-only LSU. Issues one

---
 rtl/gpu_pkg.sv | 14 +
 rtl/lsu_timeout_ctr.sv | 48 ++++
 rtl/lsu_unit.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared core pipeline phases and LSU state encoding
package gpu_pkg;

   localparam logic [2:0] REQUEST = 3'b011;
   localparam logic [2:0] UPDATE  = 3'b110;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      REQUESTING = 2'd1,
      WAITING    = 2'd2,
      DONE       = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_timeout_ctr.sv
// rtl/lsu_timeout_ctr.sv - saturating WAITING-cycle counter with expiry flag
module lsu_timeout_ctr #(
   parameter int TIMEOUT_CYC = 0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic count,
   output logic expire
);

   generate
      if (TIMEOUT_CYC == 0) begin : g_off
         // Timeout disabled: no storage, never expires.
         logic unused_in;
         assign unused_in = clk ^ reset_n ^ clear ^ count;
         assign expire    = 1'b0;
      end else begin : g_on
         localparam int            CW   = $clog2(TIMEOUT_CYC + 1);
         localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;

         // Next count: clear wins, otherwise step and stick at the last value.
         always_comb begin
            cnt_d = cnt_q;
            if (clear) begin
               cnt_d = '0;
            end else if (count && (cnt_q != LAST)) begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // Count register.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign expire = (cnt_q == LAST);
      end
   endgenerate

endmodule

// File: rtl/lsu_unit.sv
// rtl/lsu_unit.sv - per-thread load/store unit with optional response timeout
module lsu_unit
   import gpu_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [2:0]        core_state,
   input  logic              decoded_mem_read_enable,
   input  logic              decoded_mem_write_enable,
   input  logic [DATA_W-1:0] rs,
   input  logic [DATA_W-1:0] rt,
   output logic              mem_read_valid,
   output logic [ADDR_W-1:0] mem_read_address,
   input  logic              mem_read_ready,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              mem_write_valid,
   output logic [ADDR_W-1:0] mem_write_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic              mem_write_ready,
   output logic [1:0]        lsu_state,
   output logic [DATA_W-1:0] lsu_out,
   output logic              lsu_error
);

   lsu_state_t        state_q,    state_d;
   logic              rd_valid_q, rd_valid_d;
   logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
   logic              wr_valid_q, wr_valid_d;
   logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
   logic [DATA_W-1:0] wr_data_q,  wr_data_d;
   logic [DATA_W-1:0] out_q,      out_d;
   logic              err_q,      err_d;

   logic ctr_clear;
   logic ctr_count;
   logic ctr_expire;

   // Only the low ADDR_W bits of rs form the address.
   logic unused_rs;
   assign unused_rs = ^rs;

   lsu_timeout_ctr #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (ctr_clear),
      .count   (ctr_count),
      .expire  (ctr_expire)
   );

   // Next-state and output computation; enable low leaves everything as is.
   always_comb begin
      state_d    = state_q;
      rd_valid_d = rd_valid_q;
      rd_addr_d  = rd_addr_q;
      wr_valid_d = wr_valid_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      out_d      = out_q;
      err_d      = err_q;
      ctr_clear  = 1'b0;
      ctr_count  = 1'b0;
      if (enable) begin
         unique case (state_q)
            IDLE: begin
               if ((core_state == REQUEST) &&
                   (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                  state_d = REQUESTING;
                  err_d   = 1'b0;
               end
            end
            REQUESTING: begin
               // Load takes priority when both decode flags are set.
               if (decoded_mem_read_enable) begin
                  rd_valid_d = 1'b1;
                  rd_addr_d  = rs[ADDR_W-1:0];
                  ctr_clear  = 1'b1;
                  state_d    = WAITING;
               end else if (decoded_mem_write_enable) begin
                  wr_valid_d = 1'b1;
                  wr_addr_d  = rs[ADDR_W-1:0];
                  wr_data_d  = rt;
                  ctr_clear  = 1'b1;
                  state_d    = WAITING;
               end
            end
            WAITING: begin
               ctr_count = 1'b1;
               // A ready arriving on the expiry cycle still completes normally.
               if (rd_valid_q && mem_read_ready) begin
                  rd_valid_d = 1'b0;
                  out_d      = mem_read_data;
                  state_d    = DONE;
               end else if (wr_valid_q && mem_write_ready) begin
                  wr_valid_d = 1'b0;
                  state_d    = DONE;
               end else if (ctr_expire) begin
                  rd_valid_d = 1'b0;
                  wr_valid_d = 1'b0;
                  err_d      = 1'b1;
                  state_d    = DONE;
               end
            end
            DONE: begin
               if (core_state == UPDATE) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State and registered outputs; reset aborts any in-flight operation.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         rd_valid_q <= 1'b0;
         rd_addr_q  <= '0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         out_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_valid_q <= rd_valid_d;
         rd_addr_q  <= rd_addr_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         out_q      <= out_d;
         err_q      <= err_d;
      end
   end

   assign mem_read_valid    = rd_valid_q;
   assign mem_read_address  = rd_addr_q;
   assign mem_write_valid   = wr_valid_q;
   assign mem_write_address = wr_addr_q;
   assign mem_write_data    = wr_data_q;
   assign lsu_state         = state_q;
   assign lsu_out           = out_q;
   assign lsu_error         = err_q;

endmodule
